// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of independent programmable clock dividers.
// Each channel produces a registered divided level (out_o) with separately
// programmable high and low phase lengths, plus an optional one-cycle tick
// strobe at the start of every high phase.
// Optional feature macro: CLKGEN_TICK_EN (adds the tick_o port and its registers).
module clk_div_bank #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [CHANNELS-1:0]       en_i,
    input  logic                      load_i,
    input  logic [CHANNELS*CNT_W-1:0] high_cnt_i,
    input  logic [CHANNELS*CNT_W-1:0] low_cnt_i,
    input  logic                      sync_i,
    output logic [CHANNELS-1:0]       out_o
`ifdef CLKGEN_TICK_EN
    ,
    output logic [CHANNELS-1:0]       tick_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    // A programmed length of zero behaves as one, so the minimum period is 2.
    function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_ZERO) begin
            r = CNT_ONE;
        end else begin
            r = v;
        end
        return r;
    endfunction

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] act_hi_q, act_hi_d;
        logic [CNT_W-1:0] act_lo_q, act_lo_d;
        logic [CNT_W-1:0] sh_hi_q, sh_hi_d;
        logic [CNT_W-1:0] sh_lo_q, sh_lo_d;
        logic             out_q, out_d;
        logic             hi_done_s, lo_done_s, start_s;

        // Next-state logic: shadow capture, phase counting and period restarts.
        always_comb begin
            // The shadow seen this cycle already includes a same-cycle LOAD,
            // so a SYNC or restart coinciding with LOAD picks up the new values.
            sh_hi_d   = load_i ? clamp_cnt(high_cnt_i[g*CNT_W +: CNT_W]) : sh_hi_q;
            sh_lo_d   = load_i ? clamp_cnt(low_cnt_i[g*CNT_W +: CNT_W])  : sh_lo_q;
            state_d   = state_q;
            cnt_d     = cnt_q;
            act_hi_d  = act_hi_q;
            act_lo_d  = act_lo_q;
            hi_done_s = (cnt_q == act_hi_q);
            lo_done_s = (cnt_q == act_lo_q);
            // SYNC beats a natural boundary; both restart the same way.
            start_s   = en_i[g] & (sync_i | (state_q == ST_IDLE) |
                                   ((state_q == ST_LOW) & lo_done_s));
            if (start_s) begin
                state_d  = ST_HIGH;
                cnt_d    = CNT_ONE;
                act_hi_d = sh_hi_d;
                act_lo_d = sh_lo_d;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_d = CNT_ZERO;
                    end
                    ST_HIGH: begin
                        if (hi_done_s) begin
                            state_d = ST_LOW;
                            cnt_d   = CNT_ONE;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    ST_LOW: begin
                        // Reaching the end here means EN is low: stop cleanly.
                        if (lo_done_s) begin
                            state_d = ST_IDLE;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                    end
                endcase
            end
            out_d = (state_d == ST_HIGH);
        end

        // Channel state, counters, shadow/active lengths and divided output.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                state_q  <= ST_IDLE;
                cnt_q    <= CNT_ZERO;
                act_hi_q <= CNT_ONE;
                act_lo_q <= CNT_ONE;
                sh_hi_q  <= CNT_ONE;
                sh_lo_q  <= CNT_ONE;
                out_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                act_hi_q <= act_hi_d;
                act_lo_q <= act_lo_d;
                sh_hi_q  <= sh_hi_d;
                sh_lo_q  <= sh_lo_d;
                out_q    <= out_d;
            end
        end

        assign out_o[g] = out_q;

`ifdef CLKGEN_TICK_EN
        logic tick_q;

        // Tick strobe: one cycle, on every entry into the high phase.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                tick_q <= 1'b0;
            end else begin
                tick_q <= start_s;
            end
        end

        assign tick_o[g] = tick_q;
`endif
    end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Bank of independent programmable clock dividers, all running from one system clock.
- Each channel produces a divided level output with runtime-programmable high and low phase lengths, so odd divide ratios and arbitrary duty cycles are supported.
- Each channel also produces a one-cycle TICK strobe for use as a clock enable.
- Sits between the system clock and slower peripherals (UART baud, SPI SCLK, timers) that need derived rates.

Parameters:
- CHANNELS, 4, number of independent divider channels (1..16).
- CNT_W, 16, width of each high/low phase count.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- EN  in  CHANNELS  per-channel run enable.
- LOAD  in  1  one-cycle strobe; captures HIGH_CNT/LOW_CNT into shadow registers for all channels.
- HIGH_CNT  in  CHANNELS*CNT_W  high-phase length in CLK cycles; channel i at bits [i*CNT_W +: CNT_W].
- LOW_CNT  in  CHANNELS*CNT_W  low-phase length in CLK cycles; same packing as HIGH_CNT.
- SYNC  in  1  one-cycle strobe; restarts all enabled channels in phase.
- OUT  out  CHANNELS  divided clock level, registered.
- TICK  out  CHANNELS  one-cycle pulse coincident with each OUT rising edge (optional, see below).

Behaviour:
- Reset (RST_N low, async):
  - OUT=0, TICK=0.
  - All channels in IDLE, phase counters=0.
  - Shadow and active counts = 1.
- Per-channel FSM:
  - IDLE: OUT=0. When EN[i]=1, the next edge copies shadow to active, enters HIGH, sets counter=1, and drives OUT=1 and TICK=1.
  - HIGH: OUT=1. When counter==active_high, go to LOW with counter=1; otherwise counter+1.
  - LOW: OUT=0. When counter==active_low, the period ends:
    - if EN[i]=1: copy shadow to active, enter HIGH, pulse TICK;
    - if EN[i]=0: go to IDLE.
    - Otherwise counter+1.
- Count rules:
  - Period = active_high + active_low cycles; OUT is high for exactly active_high cycles.
  - A programmed count of 0 is treated as 1, so the minimum period is 2 (OUT toggles every cycle).
  - Counters never wrap; the maximum phase is 2^CNT_W-1 cycles.
- LOAD:
  - Updates shadow registers only.
  - New values take effect at the next period boundary or IDLE exit, never mid-phase; OUT never glitches.
  - LOAD while a channel is in IDLE is applied when the channel starts.
- EN deassert:
  - Not immediate; the channel completes its current period (through the end of LOW), then enters IDLE with OUT=0.
  - EN reasserted before the boundary cancels the stop; the channel continues seamlessly.
- SYNC:
  - On the next edge, every channel with EN=1 copies shadow to active, enters HIGH with counter=1, and pulses TICK, regardless of current state.
  - Channels with EN=0 ignore SYNC.
- Simultaneous events:
  - LOAD+SYNC in the same cycle: SYNC uses the newly loaded values.
  - SYNC takes priority over a natural period boundary in the same cycle.
- Latency: EN rise (or SYNC) at edge n gives OUT=1 and TICK=1 after edge n+1.
- Reset mid-operation: asynchronously forces the reset state; shadow values are lost and must be reloaded.

Optional Feature:
- Macro: CLKGEN_TICK_EN.
- Defined: TICK port exists and behaves as above.
- Undefined: TICK port and its registers are removed; OUT behaviour is identical.

Test Plan:
- Reset, then LOAD hi=2 lo=2 on ch0 and EN[0]=1 -> OUT[0] pattern 1100 repeating (period 4), TICK[0] high on the first of every 4 cycles.
- hi=1 lo=2 (divide by 3) and hi=0 lo=0 -> OUT 100 repeating; OUT toggles every cycle (zero treated as 1).
- Running hi=3 lo=3, LOAD hi=1 lo=1 mid-HIGH -> current 6-cycle period completes unchanged, then 2-cycle period; no short pulse.
- ch0 hi=2 lo=2, ch1 hi=4 lo=4 out of phase, assert SYNC -> both OUT rise on the same edge one cycle later; TICK[0]/TICK[1] coincide.
- EN[0] dropped in the second HIGH cycle (hi=2 lo=2) -> OUT stays high 1 more cycle, low 2 cycles, then IDLE with OUT=0 held.
- RST_N asserted mid-LOW asynchronously -> OUT=0 and TICK=0 immediately, before any CLK edge; after release with EN=1, OUT uses hi=lo=1.
